// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the rv32im core: register index width and
// the EX-stage operand forwarding select encoding.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/ex_forwarding_unit_fwd_select.sv
// Single-operand forwarding comparator: picks the youngest in-flight producer
// of rs, never forwarding x0.
module fwd_select #(
   parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] MEM_rd,
   input  logic                  MEM_regwrite,
   input  logic [REG_ADDR_W-1:0] WB_rd,
   input  logic                  WB_regwrite,
   output cpu_pkg::fwd_sel_t     sel
);
   import cpu_pkg::*;

   always_comb begin
      sel = FWD_NONE;
      if (MEM_regwrite && (MEM_rd != '0) && (MEM_rd == rs)) begin
         sel = FWD_MEM;
      end else if (WB_regwrite && (WB_rd != '0) && (WB_rd == rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/ex_forwarding_unit.sv
// EX-stage forwarding unit: combinational ALU operand selects plus
// clocked hazard-statistics counters for performance debug.
module ex_forwarding_unit #(
   parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] EX_rs1,
   input  logic [REG_ADDR_W-1:0] EX_rs2,
   input  logic [REG_ADDR_W-1:0] MEM_rd,
   input  logic                  MEM_regwrite,
   input  logic [REG_ADDR_W-1:0] WB_rd,
   input  logic                  WB_regwrite,
   input  logic                  count_en,
   input  logic                  count_clr,
   output logic [1:0]            forwardA,
   output logic [1:0]            forwardB,
   output logic [CNT_W-1:0]      fwd_mem_cnt,
   output logic [CNT_W-1:0]      fwd_wb_cnt
);
   import cpu_pkg::*;

   fwd_sel_t   sel_a;
   fwd_sel_t   sel_b;
   logic [1:0] mem_inc;
   logic [1:0] wb_inc;

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs           (EX_rs1),
      .MEM_rd       (MEM_rd),
      .MEM_regwrite (MEM_regwrite),
      .WB_rd        (WB_rd),
      .WB_regwrite  (WB_regwrite),
      .sel          (sel_a)
   );

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs           (EX_rs2),
      .MEM_rd       (MEM_rd),
      .MEM_regwrite (MEM_regwrite),
      .WB_rd        (WB_rd),
      .WB_regwrite  (WB_regwrite),
      .sel          (sel_b)
   );

   assign forwardA = sel_a;
   assign forwardB = sel_b;

   // Each operand contributes at most one forward per cycle, so 0..2 per stage.
   always_comb begin
      mem_inc = {1'b0, sel_a == FWD_MEM} + {1'b0, sel_b == FWD_MEM};
      wb_inc  = {1'b0, sel_a == FWD_WB}  + {1'b0, sel_b == FWD_WB};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_mem_cnt <= '0;
         fwd_wb_cnt  <= '0;
      end else if (count_clr) begin
         fwd_mem_cnt <= '0;
         fwd_wb_cnt  <= '0;
      end else if (count_en) begin
         fwd_mem_cnt <= fwd_mem_cnt + CNT_W'(mem_inc);
         fwd_wb_cnt  <= fwd_wb_cnt + CNT_W'(wb_inc);
      end
   end

endmodule

// File: tb/tb_ex_forwarding_unit.sv
// Scoreboard bench for ex_forwarding_unit: select patterns, x0/regwrite gating,
// counter accumulate/clear/wrap and asynchronous reset.
module tb_ex_forwarding_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] EX_rs1, EX_rs2, MEM_rd, WB_rd;
   logic       MEM_regwrite, WB_regwrite, count_en, count_clr;
   logic [1:0] forwardA, forwardB, sw_fa, sw_fb;
   logic [31:0] fwd_mem_cnt, fwd_wb_cnt;
   logic [2:0]  sm_cnt, sw_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      name;
      logic [1:0] a;
      logic [1:0] b;
   } sel_exp_t;

   typedef struct {
      string       name;
      logic [31:0] m;
      logic [31:0] w;
      logic [2:0]  sm;
      logic [2:0]  sw;
   } cnt_exp_t;

   sel_exp_t sel_q[$];
   cnt_exp_t cnt_q[$];
   sel_exp_t se;
   cnt_exp_t ce;

   always #5 clk = ~clk;

   ex_forwarding_unit dut (
      .clk(clk), .rst_n(rst_n), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
      .MEM_rd(MEM_rd), .MEM_regwrite(MEM_regwrite), .WB_rd(WB_rd),
      .WB_regwrite(WB_regwrite), .count_en(count_en), .count_clr(count_clr),
      .forwardA(forwardA), .forwardB(forwardB),
      .fwd_mem_cnt(fwd_mem_cnt), .fwd_wb_cnt(fwd_wb_cnt)
   );

   // Narrow-counter copy so wrap-around is reachable in a few cycles.
   ex_forwarding_unit #(.REG_ADDR_W(5), .CNT_W(3)) dut_small (
      .clk(clk), .rst_n(rst_n), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
      .MEM_rd(MEM_rd), .MEM_regwrite(MEM_regwrite), .WB_rd(WB_rd),
      .WB_regwrite(WB_regwrite), .count_en(count_en), .count_clr(count_clr),
      .forwardA(sw_fa), .forwardB(sw_fb),
      .fwd_mem_cnt(sm_cnt), .fwd_wb_cnt(sw_cnt)
   );

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] mrd, input logic mwe,
                        input logic [4:0] wrd, input logic wwe);
      EX_rs1 = r1; EX_rs2 = r2;
      MEM_rd = mrd; MEM_regwrite = mwe;
      WB_rd = wrd; WB_regwrite = wwe;
   endtask

   function automatic logic [1:0] model(input logic [4:0] rs, input logic [4:0] mrd,
                                        input logic mwe, input logic [4:0] wrd,
                                        input logic wwe);
      logic hit_m, hit_w;
      hit_m = mwe && (rs == mrd) && (rs != 5'd0);
      hit_w = wwe && (rs == wrd) && (rs != 5'd0);
      return hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; count_en = 1'b0; count_clr = 1'b0;
      drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1);
      sel_q.push_back('{"reset_sel", 2'b10, 2'b01});
      cnt_q.push_back('{"reset_cnt", 32'd0, 32'd0, 3'd0, 3'd0});
      #1;
      while (sel_q.size() != 0) begin
         se = sel_q.pop_front(); tests++;
         if (forwardA !== se.a || forwardB !== se.b) begin
            fails++;
            $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b);
         end
      end
      while (cnt_q.size() != 0) begin
         ce = cnt_q.pop_front(); tests++;
         if (fwd_mem_cnt !== ce.m || fwd_wb_cnt !== ce.w || sm_cnt !== ce.sm || sw_cnt !== ce.sw) begin
            fails++;
            $display("FAIL %s: cnt=%0d/%0d small=%0d/%0d expected %0d/%0d small %0d/%0d",
                     ce.name, fwd_mem_cnt, fwd_wb_cnt, sm_cnt, sw_cnt, ce.m, ce.w, ce.sm, ce.sw);
         end
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_selects();
      @(negedge clk);
      drive(5'd1, 5'd2, 5'd3, 1'b1, 5'd4, 1'b1); sel_q.push_back('{"no_hazard", 2'b00, 2'b00}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd4, 1'b1); sel_q.push_back('{"mem_fwd", 2'b10, 2'b00}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd1, 1'b1); sel_q.push_back('{"mem_priority", 2'b10, 2'b00}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1); sel_q.push_back('{"mixed", 2'b10, 2'b01}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      drive(5'd1, 5'd1, 5'd1, 1'b0, 5'd1, 1'b1); sel_q.push_back('{"wb_both", 2'b01, 2'b01}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      drive(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1); sel_q.push_back('{"x0_never", 2'b00, 2'b00}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      drive(5'd5, 5'd2, 5'd5, 1'b0, 5'd4, 1'b1); sel_q.push_back('{"regwrite_gate", 2'b00, 2'b00}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      drive(5'd7, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0); sel_q.push_back('{"wb_regwrite_gate", 2'b00, 2'b00}); #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
   endtask

   task automatic test_random();
      logic [4:0] r1, r2, mrd, wrd;
      logic mwe, wwe;
      for (int i = 0; i < 60; i++) begin
         r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
         mrd = 5'($urandom_range(0, 3)); wrd = 5'($urandom_range(0, 3));
         mwe = 1'($urandom_range(0, 1)); wwe = 1'($urandom_range(0, 1));
         drive(r1, r2, mrd, mwe, wrd, wwe);
         sel_q.push_back('{"random", model(r1, mrd, mwe, wrd, wwe), model(r2, mrd, mwe, wrd, wwe)});
         #1;
         se = sel_q.pop_front(); tests++;
         if (forwardA !== se.a || forwardB !== se.b) begin
            fails++;
            $display("FAIL %s: rs=%0d/%0d mem=%0d/%b wb=%0d/%b A/B=%b/%b expected %b/%b",
                     se.name, r1, r2, mrd, mwe, wrd, wwe, forwardA, forwardB, se.a, se.b);
         end
      end
   endtask

   task automatic test_counters();
      @(negedge clk); count_clr = 1'b1; @(negedge clk); count_clr = 1'b0;
      drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1);
      count_en = 1'b1;
      repeat (3) @(negedge clk);
      count_en = 1'b0;
      cnt_q.push_back('{"count_3", 32'd3, 32'd3, 3'd3, 3'd3});
      #1;
      ce = cnt_q.pop_front(); tests++;
      if (fwd_mem_cnt !== ce.m || fwd_wb_cnt !== ce.w || sm_cnt !== ce.sm || sw_cnt !== ce.sw) begin
         fails++;
         $display("FAIL %s: cnt=%0d/%0d small=%0d/%0d expected %0d/%0d small %0d/%0d",
                  ce.name, fwd_mem_cnt, fwd_wb_cnt, sm_cnt, sw_cnt, ce.m, ce.w, ce.sm, ce.sw);
      end
      // Clear must win over a simultaneous enable.
      @(negedge clk); count_clr = 1'b1; count_en = 1'b1;
      @(negedge clk); count_clr = 1'b0; count_en = 1'b0;
      cnt_q.push_back('{"clear_priority", 32'd0, 32'd0, 3'd0, 3'd0});
      #1;
      ce = cnt_q.pop_front(); tests++;
      if (fwd_mem_cnt !== ce.m || fwd_wb_cnt !== ce.w || sm_cnt !== ce.sm || sw_cnt !== ce.sw) begin
         fails++;
         $display("FAIL %s: cnt=%0d/%0d small=%0d/%0d expected %0d/%0d small %0d/%0d",
                  ce.name, fwd_mem_cnt, fwd_wb_cnt, sm_cnt, sw_cnt, ce.m, ce.w, ce.sm, ce.sw);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      drive(5'd1, 5'd1, 5'd1, 1'b1, 5'd1, 1'b1);
      count_en = 1'b1;
      repeat (5) @(negedge clk);
      count_en = 1'b0;
      cnt_q.push_back('{"double_inc_wrap", 32'd10, 32'd0, 3'd2, 3'd0});
      #1;
      ce = cnt_q.pop_front(); tests++;
      if (fwd_mem_cnt !== ce.m || fwd_wb_cnt !== ce.w || sm_cnt !== ce.sm || sw_cnt !== ce.sw) begin
         fails++;
         $display("FAIL %s: cnt=%0d/%0d small=%0d/%0d expected %0d/%0d small %0d/%0d",
                  ce.name, fwd_mem_cnt, fwd_wb_cnt, sm_cnt, sw_cnt, ce.m, ce.w, ce.sm, ce.sw);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk); count_clr = 1'b1; @(negedge clk); count_clr = 1'b0;
      drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1);
      count_en = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      sel_q.push_back('{"sel_in_reset", 2'b10, 2'b01});
      cnt_q.push_back('{"async_reset", 32'd0, 32'd0, 3'd0, 3'd0});
      #1;
      se = sel_q.pop_front(); tests++;
      if (forwardA !== se.a || forwardB !== se.b) begin fails++; $display("FAIL %s: A/B=%b/%b expected %b/%b", se.name, forwardA, forwardB, se.a, se.b); end
      ce = cnt_q.pop_front(); tests++;
      if (fwd_mem_cnt !== ce.m || fwd_wb_cnt !== ce.w || sm_cnt !== ce.sm || sw_cnt !== ce.sw) begin
         fails++;
         $display("FAIL %s: cnt=%0d/%0d small=%0d/%0d expected %0d/%0d small %0d/%0d",
                  ce.name, fwd_mem_cnt, fwd_wb_cnt, sm_cnt, sw_cnt, ce.m, ce.w, ce.sm, ce.sw);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); count_en = 1'b0;
      cnt_q.push_back('{"resume_after_reset", 32'd1, 32'd1, 3'd1, 3'd1});
      #1;
      ce = cnt_q.pop_front(); tests++;
      if (fwd_mem_cnt !== ce.m || fwd_wb_cnt !== ce.w || sm_cnt !== ce.sm || sw_cnt !== ce.sw) begin
         fails++;
         $display("FAIL %s: cnt=%0d/%0d small=%0d/%0d expected %0d/%0d small %0d/%0d",
                  ce.name, fwd_mem_cnt, fwd_wb_cnt, sm_cnt, sw_cnt, ce.m, ce.w, ce.sm, ce.sw);
      end
   endtask

   initial begin
      test_reset();
      test_selects();
      test_random();
      test_counters();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
